gpio_input_conditioner: RTL and testbench

//   Per-pin GPIO input conditioning between board pads and the rvx gpio_input bus.

---
 rtl/gpio_input_conditioner.sv | 56 +++++
 tb/tb_gpio_input_conditioner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin pad synchronizer, debounce, edge pulses and sticky event flags
module gpio_input_conditioner #(
    parameter int GPIO_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_pad_in,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    input  logic [GPIO_WIDTH-1:0] event_clear,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    output logic [GPIO_WIDTH-1:0] rise_pulse,
    output logic [GPIO_WIDTH-1:0] fall_pulse,
    output logic [GPIO_WIDTH-1:0] event_pending
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] sample, next_stable;
    assign sample = (gpio_oe & gpio_output) | (~gpio_oe & sync_q[SYNC_STAGES-1]);
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
    // a driven pin bypasses debounce; otherwise the counter tracks consecutive differing samples
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic differ, accept;
        assign differ = sample[i] != gpio_input[i];
        assign accept = gpio_oe[i] || (differ && cnt == CNT_MAX);
        assign next_stable[i] = accept ? sample[i] : gpio_input[i];
        always_ff @(posedge clock) begin
            if (reset) cnt <= '0;
            else cnt <= (accept || !differ) ? '0 : cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            gpio_input    <= '0;
            rise_pulse    <= '0;
            fall_pulse    <= '0;
            event_pending <= '0;
        end else begin
            gpio_input    <= next_stable;
            rise_pulse    <= next_stable & ~gpio_input;
            fall_pulse    <= ~next_stable & gpio_input;
            event_pending <= (next_stable ^ gpio_input) | (event_pending & ~event_clear);
        end
    end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed vector table, corner sequences and random stimulus against a sample-history model
module tb_gpio_input_conditioner;
    localparam int W = 3, SYNC = 2, DEB = 4;
    logic clock = 0, reset = 1;
    logic [W-1:0] gpio_pad_in = '0, gpio_oe = '0, gpio_output = '0, event_clear = '0;
    logic [W-1:0] gpio_input, rise_pulse, fall_pulse, event_pending;
    int total = 0, bad = 0;

    gpio_input_conditioner #(.GPIO_WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .reset(reset), .gpio_pad_in(gpio_pad_in), .gpio_oe(gpio_oe),
        .gpio_output(gpio_output), .event_clear(event_clear), .gpio_input(gpio_input),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_pending(event_pending)
    );

    always #5 clock = ~clock;

    // Reference: the pad value seen SYNC edges ago is the sample; a new level is accepted once the
    // last DEB samples since the last restart all differ from the current level.
    logic [W-1:0] m_in = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [W-1:0] m_pads [$] = '{3'b000, 3'b000};
    bit m_hist [W][$];
    always @(posedge clock) begin
        logic [W-1:0] nxt, seen;
        bit s, ok;
        if (reset) begin
            m_in = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            m_pads = '{3'b000, 3'b000};
            for (int c = 0; c < W; c++) m_hist[c].delete();
        end else begin
            seen = m_pads.pop_front();
            m_pads.push_back(gpio_pad_in);
            nxt = m_in;
            for (int c = 0; c < W; c++) begin
                if (gpio_oe[c]) begin
                    nxt[c] = gpio_output[c];
                    m_hist[c].delete();
                end else begin
                    s = seen[c];
                    m_hist[c].push_back(s);
                    if (m_hist[c].size() > DEB) void'(m_hist[c].pop_front());
                    ok = m_hist[c].size() == DEB;
                    foreach (m_hist[c][k]) if (m_hist[c][k] == m_in[c]) ok = 0;
                    if (ok) begin
                        nxt[c] = s;
                        m_hist[c].delete();
                    end
                end
            end
            m_rise = nxt & ~m_in;
            m_fall = m_in & ~nxt;
            m_pend = (nxt ^ m_in) | (m_pend & ~event_clear);
            m_in = nxt;
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] p, o, d, c);
        reset = r; gpio_pad_in = p; gpio_oe = o; gpio_output = d; event_clear = c;
        @(negedge clock);
        chk("model_in", 12'(gpio_input), 12'(m_in));
        chk("model_rise", 12'(rise_pulse), 12'(m_rise));
        chk("model_fall", 12'(fall_pulse), 12'(m_fall));
        chk("model_pend", 12'(event_pending), 12'(m_pend));
    endtask

    typedef struct {
        logic r;
        logic [W-1:0] pad, oe, out, clr, e_in, e_rise, e_fall, e_pend;
    } vec_t;
    vec_t vecs [$];

    function automatic void add(int n, logic r, logic [W-1:0] p, o, d, c, ei, er, ef, ep);
        for (int k = 0; k < n; k++) vecs.push_back('{r, p, o, d, c, ei, er, ef, ep});
    endfunction

    initial begin
        logic [W-1:0] p, o, d, c, seen;
        // reset, pad0 rise, oe-driven ch2, set-wins clear, oe release, short and 4-cycle pulses on ch1
        add(1, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        add(5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        add(1, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001);
        add(1, 0, 3'b001, 3'b100, 3'b100, 3'b000, 3'b101, 3'b100, 3'b000, 3'b101);
        add(1, 0, 3'b001, 3'b100, 3'b100, 3'b000, 3'b101, 3'b000, 3'b000, 3'b101);
        add(5, 0, 3'b000, 3'b100, 3'b100, 3'b000, 3'b101, 3'b000, 3'b000, 3'b101);
        add(1, 0, 3'b000, 3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b001, 3'b101);
        add(1, 0, 3'b000, 3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b100);
        add(3, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100);
        add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100);
        add(3, 0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        add(5, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        add(4, 0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b110);
        add(3, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b110);
        add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b110);
        add(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110);
        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].pad, vecs[n].oe, vecs[n].out, vecs[n].clr);
            chk($sformatf("vec%0d_in", n), 12'(gpio_input), 12'(vecs[n].e_in));
            chk($sformatf("vec%0d_rise", n), 12'(rise_pulse), 12'(vecs[n].e_rise));
            chk($sformatf("vec%0d_fall", n), 12'(fall_pulse), 12'(vecs[n].e_fall));
            chk($sformatf("vec%0d_pend", n), 12'(event_pending), 12'(vecs[n].e_pend));
        end

        // reset in the middle of a count, then release with the pad already high
        for (int k = 0; k < 4; k++) step(0, 3'b001, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 2; k++) begin
            step(1, 3'b001, 3'b000, 3'b000, 3'b000);
            chk("rst_outputs", {gpio_input, rise_pulse, fall_pulse, event_pending}, 12'h000);
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 3'b001, 3'b000, 3'b000, 3'b000);
            chk($sformatf("rel_in%0d", k), 12'(gpio_input[0]), 12'(k == 6));
        end
        chk("rel_rise", 12'(rise_pulse), 12'h001);
        chk("rel_pend", 12'(event_pending), 12'h001);

        // staggered pulses: only the 4-cycle and held changes are accepted
        for (int k = 0; k < 10; k++) step(0, 3'b000, 3'b000, 3'b000, 3'b000);
        seen = '0;
        for (int t = 0; t < 14; t++) begin
            p = {t >= 5 ? 1'b1 : 1'b0, (t >= 2 && t < 5) ? 1'b1 : 1'b0, t < 4 ? 1'b1 : 1'b0};
            step(0, p, 3'b000, 3'b000, 3'b000);
            seen |= rise_pulse;
        end
        chk("stagger_rises", 12'(seen), 12'h005);

        // random traffic with slow pad toggling so both short glitches and accepted levels occur
        p = gpio_pad_in; o = '0; d = '0;
        for (int t = 0; t < 4000; t++) begin
            for (int k = 0; k < W; k++) if ($urandom_range(5) == 0) p[k] = ~p[k];
            if ($urandom_range(24) == 0) o = W'($urandom);
            if ($urandom_range(3) == 0) d = W'($urandom);
            c = W'($urandom) & W'($urandom);
            step($urandom_range(399) == 0, p, o, d, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
